// File: rtl/ms_usr_pkg.sv
// Shared definitions for the master-slave universal shift register:
// operation codes, controller state encoding and a mode classifier.
package ms_usr_pkg;

    // Operation codes presented on mode together with start
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for modes that repeat one step 'count' times; the rest complete in one edge
    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ms_usr_next.sv
// One-step next-value function of the universal shift register.
// Purely combinational: given the current contents and an operation code,
// produce what the register holds after a single step of that operation.
module ms_usr_next
    import ms_usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_pdin,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    output logic [WIDTH-1:0] o_next
);

    // Decode the operation into a single-step result
    always_comb begin
        o_next = i_q;
        case (i_mode)
            MODE_HOLD: o_next = i_q;
            MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_sin_r};
            MODE_SHR:  o_next = {i_sin_l, i_q[WIDTH-1:1]};
            MODE_ROL:  o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ROR:  o_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_LOAD: o_next = i_pdin;
            MODE_ASR:  o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            MODE_CLR:  o_next = '0;
            default:   o_next = i_q;
        endcase
    end

endmodule

// File: rtl/ms_univ_shift_reg.sv
// Universal shift register on rising-edge (master-slave) storage.
// Single-cycle operations (hold, load, clear) complete at the start edge;
// shift/rotate operations repeat one step per edge for 'count' edges while
// busy is high. Every operation ends with a one-cycle done pulse. 'master'
// is the value q will take at the next rising edge, so q simply registers it.
module ms_univ_shift_reg
    import ms_usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] pdin,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] master,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_q;

    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_master;
    logic             w_latch;
    logic             w_busy;
    logic             w_done;

    // In IDLE the step follows the live request; during a shift it follows the latched mode
    assign w_step_mode = (r_state == ST_IDLE) ? mode : r_mode;

    ms_usr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_q     (r_q),
        .i_mode  (w_step_mode),
        .i_pdin  (pdin),
        .i_sin_l (sin_l),
        .i_sin_r (sin_r),
        .o_next  (w_step)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, master selection and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_master    = r_q;
        w_latch     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_mode(mode)) begin
                        // Shifts begin on the edge after the request; q holds at the start edge
                        if (count != '0) begin
                            w_latch     = 1'b1;
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_master    = w_step;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                w_busy   = 1'b1;
                w_master = w_step;
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Storage: q always takes the master value, which already encodes hold cases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_master;
        end
    end

    // Latched operation and remaining-shift counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_HOLD;
            r_rem  <= '0;
        end else if (w_latch) begin
            r_mode <= mode;
            r_rem  <= count;
        end else if (r_state == ST_SHIFT) begin
            r_rem  <= r_rem - CNT_W'(1);
        end
    end

    assign master = w_master;
    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = w_busy;
    assign done   = w_done;

endmodule

// File: tb/tb_ms_univ_shift_reg.sv
// Self-checking bench for ms_univ_shift_reg: directed scenarios with literal
// expectations, then randomized operations checked against an arithmetic model.
module tb_ms_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  pdin;
    logic          sin_l;
    logic          sin_r;
    logic [W-1:0]  master;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ms_univ_shift_reg #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .count  (count),
        .pdin   (pdin),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .master (master),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 shifting, 2 done pulse
    int unsigned m_q     = 0;
    int          m_phase = 0;
    int          m_rem   = 0;
    int          m_mode  = 0;

    function automatic int unsigned shift_once(input int unsigned v, input int md,
                                               input bit sl, input bit sr);
        int unsigned full = 1 << W;
        int unsigned half = 1 << (W - 1);
        case (md)
            1:       return (v * 2 + (sr ? 1 : 0)) % full;
            2:       return v / 2 + (sl ? half : 0);
            3:       return (v * 2) % full + v / half;
            4:       return v / 2 + (v % 2) * half;
            6:       return v / 2 + ((v >= half) ? half : 0);
            default: return v;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = 0; m_phase = 0; m_rem = 0; m_mode = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (mode == 3'd0 || mode == 3'd5 || mode == 3'd7) begin
                        if (mode == 3'd5) m_q = 32'(pdin);
                        if (mode == 3'd7) m_q = 0;
                        m_phase = 2;
                    end else if (count == '0) begin
                        m_phase = 2;
                    end else begin
                        m_mode  = int'(mode);
                        m_rem   = int'(count);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_q = shift_once(m_q, m_mode, sin_l, sin_r);
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [W-1:0] prev_master = '0;
    bit           have_prev   = 0;
    bit           rst_seen    = 0;

    always @(posedge rst) rst_seen = 1;

    always @(negedge clk) begin
        chk("q", longint'(q), longint'(m_q));
        chk("busy", longint'(busy), longint'(m_phase == 1));
        chk("done", longint'(done), longint'(m_phase == 2));
        chk("sout_l", longint'(sout_l), longint'((m_q >> (W - 1)) & 1));
        chk("sout_r", longint'(sout_r), longint'(m_q & 1));
        if (have_prev && !rst_seen && !rst)
            chk("master_predicts_q", longint'(q), longint'(prev_master));
        prev_master = master;
        have_prev   = !rst;
        rst_seen    = 0;
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [2:0] md, input logic [CW-1:0] cnt, input logic [W-1:0] pd);
        @(posedge clk); #1;
        start = 1'b1; mode = md; count = cnt; pdin = pd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] pd);
        do_start(3'b101, '0, pd);
        @(negedge clk);
        chk("load_q", longint'(q), longint'(pd));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; count = '0; pdin = '0;
        sin_l = 1'b0; sin_r = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_q", longint'(q), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: parallel load
        do_start(3'b101, '0, 8'hA5);
        @(negedge clk);
        chk("t1_q", longint'(q), 64'hA5);
        chk("t1_done", longint'(done), 1);
        chk("t1_busy", longint'(busy), 0);
        @(negedge clk);
        chk("t1_done_once", longint'(done), 0);

        // 2: rotate left by 3
        do_start(3'b011, 4'd3, '0);
        @(negedge clk);
        chk("t2_busy", longint'(busy), 1);
        chk("t2_master", longint'(master), 64'h4B);
        chk("t2_q_hold", longint'(q), 64'hA5);
        @(negedge clk); chk("t2_q1", longint'(q), 64'h4B);
        @(negedge clk); chk("t2_q2", longint'(q), 64'h96);
        @(negedge clk); chk("t2_q3", longint'(q), 64'h2D);
        chk("t2_done", longint'(done), 1);

        // 3: arithmetic shift right by 2
        do_load(8'h96);
        do_start(3'b110, 4'd2, '0);
        @(negedge clk);
        @(negedge clk); chk("t3_q1", longint'(q), 64'hCB);
        @(negedge clk); chk("t3_q2", longint'(q), 64'hE5);
        chk("t3_sout_r", longint'(sout_r), 1);

        // 4: shift left by 4 with sin_r=1; stray start during busy
        sin_r = 1'b1;
        do_load(8'h00);
        do_start(3'b001, 4'd4, '0);
        @(negedge clk);
        #1 start = 1'b1; mode = 3'b101; pdin = 8'hFF;
        @(negedge clk); chk("t4_q1", longint'(q), 64'h01);
        start = 1'b0;
        @(negedge clk); chk("t4_q2", longint'(q), 64'h03);
        @(negedge clk); chk("t4_q3", longint'(q), 64'h07);
        @(negedge clk); chk("t4_q4", longint'(q), 64'h0F);
        chk("t4_sout_l", longint'(sout_l), 0);
        chk("t4_done", longint'(done), 1);
        @(negedge clk);
        chk("t4_q_after", longint'(q), 64'h0F);
        chk("t4_single_done", longint'(done), 0);
        chk("t4_idle", longint'(busy), 0);

        // 5: zero count
        do_start(3'b010, 4'd0, '0);
        @(negedge clk);
        chk("t5_done", longint'(done), 1);
        chk("t5_q", longint'(q), 64'h0F);
        chk("t5_busy", longint'(busy), 0);

        // 6: async reset during rotate right by 7
        do_load(8'hFF);
        do_start(3'b100, 4'd7, '0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t6_busy_mid", longint'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_q", longint'(q), 0);
        chk("t6_rst_busy", longint'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", longint'(done), 0);
        end
        do_load(8'h3C);

        // Randomized operations
        sin_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            start = ($urandom_range(0, 2) == 0);
            mode  = 3'($urandom_range(0, 7));
            count = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                : CW'($urandom_range(0, 4));
            pdin  = W'($urandom);
            sin_l = 1'($urandom_range(0, 1));
            sin_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
